// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for a simple processor load/store port.
// Optional access checking is compiled in with the DMEM_ERR_CHECK_EN macro.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_WORDS = 128,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        mem_busy,
    output logic        mem_ready,
    output logic        mem_err
);

    // Handshake: a strobe is taken only at an edge where mem_busy is low; strobes seen
    // while busy are dropped, and mem_ready (with mem_err) pulses once per taken request.
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
`ifdef DMEM_ERR_CHECK_EN
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic        opRead, opWrite;
    logic [31:0] opAddr, opData;
    logic [31:0] mem [DEPTH_WORDS];

    logic          isIdle, accept, commit;
    logic          curRead, curWrite, accessErr, doRead, doWrite;
    logic [31:0]   curAddr, curData;
    logic [AW-1:0] wordIdx;

    // In IDLE the live inputs describe the access; afterwards the latched copy does.
    always_comb begin
        isIdle   = (state == IDLE);
        curRead  = isIdle ? MemRead    : opRead;
        curWrite = isIdle ? MemWrite   : opWrite;
        curAddr  = isIdle ? dAddress   : opAddr;
        curData  = isIdle ? dWriteData : opData;
        wordIdx  = AW'((curAddr - BASE_ADDR) >> 2);
`ifdef DMEM_ERR_CHECK_EN
        accessErr = (curAddr[1:0] != 2'b00)
                  || ({1'b0, curAddr} < {1'b0, BASE_ADDR})
                  || ({1'b0, curAddr} >= END_ADDR)
                  || (curRead && curWrite);
`else
        accessErr = 1'b0;
`endif
        doWrite = curWrite && !accessErr;
        doRead  = curRead && !curWrite && !accessErr;
        accept  = isIdle && (MemRead || MemWrite);
        commit  = ((state == WAIT) && (cnt == 4'd0)) || ((LATENCY == 1) && accept);
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        stateNext = RESP;
                    end else begin
                        stateNext = WAIT;
                        cntNext   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) stateNext = RESP;
                else             cntNext   = cnt - 4'd1;
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            opRead    <= 1'b0;
            opWrite   <= 1'b0;
            opAddr    <= 32'h0;
            opData    <= 32'h0;
            dReadData <= 32'h0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (accept) begin
                opRead  <= MemRead;
                opWrite <= MemWrite;
                opAddr  <= dAddress;
                opData  <= dWriteData;
            end
            if (commit && accessErr) dReadData <= 32'h0;
            else if (commit && doRead) dReadData <= mem[wordIdx];
            mem_ready <= (state == RESP);
            mem_err   <= (state == RESP) && accessErr;
        end
    end

    // Storage survives reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!rst && commit && doWrite) mem[wordIdx] <= curData;
    end

    assign mem_busy = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=1 instance checked against
// an array-based memory model with directed cases followed by random accesses.
module tb_data_mem_responder;

    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int          DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        memRead  [2];
    logic        memWrite [2];
    logic [31:0] dAddr    [2];
    logic [31:0] dWData   [2];
    logic [31:0] rdData   [2];
    logic        busy     [2];
    logic        ready    [2];
    logic        errOut   [2];

    int          lat [2] = '{2, 1};
    logic [31:0] modelMem [2][DEPTH];
    logic [31:0] modelRdata [2];
    logic [31:0] expQ [$];
    int          checkCount = 0;
    int          errorCount = 0;

    always #5 clk = ~clk;

    data_mem_responder dut0 (
        .clk(clk), .rst(rst[0]), .MemRead(memRead[0]), .MemWrite(memWrite[0]),
        .dAddress(dAddr[0]), .dWriteData(dWData[0]), .dReadData(rdData[0]),
        .mem_busy(busy[0]), .mem_ready(ready[0]), .mem_err(errOut[0])
    );

    data_mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst[1]), .MemRead(memRead[1]), .MemWrite(memWrite[1]),
        .dAddress(dAddr[1]), .dWriteData(dWData[1]), .dReadData(rdData[1]),
        .mem_busy(busy[1]), .mem_ready(ready[1]), .mem_err(errOut[1])
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One access on unit u; poke drives a stray write strobe while the unit is busy.
    task automatic doAccess(input int u, input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input bit poke, input logic [31:0] pokeAddr);
        bit err;
        int idx;
        int k;
        err = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        err = (a % 4 != 0) || (a < BASE) || (64'(a) >= 64'(BASE) + 64'(4 * DEPTH)) || (r && w);
`endif
        idx = int'(((a - BASE) / 4) % DEPTH);
        if (err)         modelRdata[u] = 32'h0;
        else if (w)      modelMem[u][idx] = d;
        else if (r)      modelRdata[u] = modelMem[u][idx];
        expQ.push_back(modelRdata[u]);

        memRead[u]  = r;
        memWrite[u] = w;
        dAddr[u]    = a;
        dWData[u]   = d;
        @(posedge clk);
        @(negedge clk);
        memRead[u]  = 1'b0;
        memWrite[u] = 1'b0;
        checkVal("busy_after_accept", 32'(busy[u]), 32'd1);
        if (poke) begin
            memWrite[u] = 1'b1;
            dAddr[u]    = pokeAddr;
            dWData[u]   = $urandom();
        end
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) memWrite[u] = 1'b0;
            if (ready[u]) break;
        end
        checkVal("ready_latency", 32'(k), 32'(lat[u]));
        checkVal("err", 32'(errOut[u]), 32'(err));
        checkVal("rdata", rdData[u], expQ.pop_front());
        checkVal("busy_at_ready", 32'(busy[u]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkVal("ready_one_cycle", 32'(ready[u]), 32'd0);
        checkVal("err_one_cycle", 32'(errOut[u]), 32'd0);
    endtask

    // Write on unit 0 with reset asserted while the request is waiting.
    task automatic abortWrite(input logic [31:0] a, input logic [31:0] d);
        memWrite[0] = 1'b1;
        dAddr[0]    = a;
        dWData[0]   = d;
        @(posedge clk);
        @(negedge clk);
        memWrite[0] = 1'b0;
        rst[0]      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        modelRdata[0] = 32'h0;
        checkVal("abort_busy", 32'(busy[0]), 32'd0);
        checkVal("abort_rdata", rdData[0], 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkVal("abort_no_ready", 32'(ready[0]), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1;
            memRead[u] = 1'b0;
            memWrite[u] = 1'b0;
            dAddr[u] = 32'h0;
            dWData[u] = 32'h0;
            modelRdata[u] = 32'h0;
            for (int i = 0; i < DEPTH; i++) modelMem[u][i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            checkVal("reset_busy", 32'(busy[u]), 32'd0);
            checkVal("reset_ready", 32'(ready[u]), 32'd0);
            checkVal("reset_err", 32'(errOut[u]), 32'd0);
            checkVal("reset_rdata", rdData[u], 32'h0);
        end

        doAccess(0, 1'b0, 1'b1, 32'h10010004, 32'hDEADBEEF, 1'b0, 32'h0);
        doAccess(0, 1'b1, 1'b0, 32'h10010004, 32'h0, 1'b0, 32'h0);
        checkVal("deadbeef_readback", rdData[0], 32'hDEADBEEF);

        doAccess(0, 1'b1, 1'b0, 32'h10010004, 32'h0, 1'b1, 32'h1001000C);
        doAccess(0, 1'b1, 1'b0, 32'h1001000C, 32'h0, 1'b0, 32'h0);

        abortWrite(32'h10010008, 32'hCAFEF00D);
        doAccess(0, 1'b1, 1'b0, 32'h10010008, 32'h0, 1'b0, 32'h0);

`ifdef DMEM_ERR_CHECK_EN
        doAccess(0, 1'b1, 1'b0, 32'h10010002, 32'h0, 1'b0, 32'h0);
        doAccess(0, 1'b1, 1'b0, 32'h10010200, 32'h0, 1'b0, 32'h0);
`else
        doAccess(0, 1'b0, 1'b1, 32'h10010200, 32'h12345678, 1'b0, 32'h0);
        doAccess(0, 1'b1, 1'b0, 32'h10010000, 32'h0, 1'b0, 32'h0);
        checkVal("wrap_readback", rdData[0], 32'h12345678);
`endif

        doAccess(1, 1'b0, 1'b1, 32'h10010020, 32'h0BADCAFE, 1'b0, 32'h0);
        doAccess(1, 1'b1, 1'b0, 32'h10010020, 32'h0, 1'b0, 32'h0);
        checkVal("lat1_readback", rdData[1], 32'h0BADCAFE);

        for (int n = 0; n < 80; n++) begin
            int u, op, sel;
            logic [31:0] a;
            u   = n % 2;
            op  = $urandom_range(0, 9);
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = BASE + 4 * $urandom_range(0, 15);
            else if (sel < 9) a = BASE + $urandom_range(0, 1023);
            else              a = $urandom();
            doAccess(u, (op < 5) || (op == 9), op >= 5, a, $urandom(),
                     $urandom_range(0, 3) == 0, BASE + 4 * $urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 128, power of two, storage size in 32-bit words.
REQ-003 SHALL have parameter LATENCY, default 2, range 1..15, clock edges from request accept to response.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port MemRead  input  1  read request strobe from processor.
REQ-007 SHALL have port MemWrite  input  1  write request strobe from processor.
REQ-008 SHALL have port dAddress  input  32  byte address of access.
REQ-009 SHALL have port dWriteData  input  32  store data.
REQ-010 SHALL have port dReadData  output  32  load data, registered.
REQ-011 SHALL have port mem_busy  output  1  request in flight, new strobes ignored.
REQ-012 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port mem_err  output  1  completion with error, valid only with mem_ready.

Function
REQ-014 SHALL implement FSM IDLE, WAIT, RESP; IDLE on reset.
REQ-015 SHALL accept a request at a rising edge in IDLE when MemRead or MemWrite is high, latching op, dAddress, dWriteData.
REQ-016 SHALL go IDLE->RESP on accept when LATENCY=1, else IDLE->WAIT with down-counter loaded to LATENCY-2; WAIT->RESP when counter is 0; RESP->IDLE unconditionally.
REQ-017 SHALL assert mem_ready for exactly one cycle, beginning LATENCY edges after the accepting edge.
REQ-018 SHALL assert mem_busy in every WAIT and RESP cycle, low in IDLE.
REQ-019 SHALL ignore strobes sampled in WAIT or RESP; no queuing; back-to-back throughput one access per LATENCY+1 cycles.
REQ-020 SHALL index storage as word (dAddress-BASE_ADDR)>>2, taking log2(DEPTH_WORDS) bits.
REQ-021 SHALL commit a write to storage at the edge entering RESP; leave dReadData unchanged on writes.
REQ-022 SHALL load dReadData with the addressed word at the edge entering RESP for reads; hold it until the next read completes.
REQ-023 SHALL return, on a read from a word written by the previous completed access, the newly written value.
REQ-024 SHALL drive mem_err low except as given in REQ-029.

Reset
REQ-025 SHALL on rst: state IDLE, counter 0, mem_busy 0, mem_ready 0, mem_err 0, dReadData 32'h0.
REQ-026 SHALL abort an in-flight access when rst is sampled high in WAIT or RESP: no storage write, no mem_ready pulse.
REQ-027 SHALL not clear storage contents on rst; contents power up as zero in simulation.

Configuration
REQ-028 SHALL use macro DMEM_ERR_CHECK_EN to compile access checking in or out.
REQ-029 SHALL, with DMEM_ERR_CHECK_EN defined, flag error if dAddress[1:0]!=0, dAddress<BASE_ADDR, dAddress>=BASE_ADDR+4*DEPTH_WORDS, or MemRead and MemWrite both high at accept. An errored access writes nothing, loads dReadData with 32'h0, and pulses mem_err together with mem_ready at normal latency.
REQ-030 SHALL, without DMEM_ERR_CHECK_EN: mem_err tied 0, dAddress[1:0] ignored, index wraps modulo DEPTH_WORDS, both strobes high treated as write only.

Verification
REQ-031 SHALL cover: defaults, write 32'hDEADBEEF to 32'h10010004, then read 32'h10010004 -> mem_ready 2 edges after each accept, dReadData=32'hDEADBEEF, mem_err=0.
REQ-032 SHALL cover: read accepted, MemWrite pulsed while mem_busy=1 -> strobe ignored, storage unchanged, single mem_ready.
REQ-033 SHALL cover: write to 32'h10010008 with rst high in WAIT -> no mem_ready; subsequent read of 32'h10010008 returns prior contents (32'h0).
REQ-034 SHALL cover, with DMEM_ERR_CHECK_EN defined: read 32'h10010002, then read 32'h10010200 -> each completes with mem_ready=1, mem_err=1, dReadData=32'h0.
REQ-035 SHALL cover, with DMEM_ERR_CHECK_EN undefined: write 32'h12345678 to 32'h10010200, read 32'h10010000 -> dReadData=32'h12345678 (wrap), mem_err=0.
REQ-036 SHALL cover: LATENCY=1, write then read same address on consecutive accepts -> mem_ready 1 edge after each accept, read returns written value.
